// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types and helper functions for the ring-code decoder
package ring_pkg;

  typedef enum logic {HUNT, LOCKED} ring_state_t;

  typedef enum logic [1:0] {CLS_ZERO, CLS_ONEHOT, CLS_ILLEGAL} ring_class_t;

  // Helpers work on a fixed wide vector; callers zero-extend and pass the real width.
  localparam int RING_MAXW = 32;
  typedef logic [RING_MAXW-1:0] ring_vec_t;

  function automatic ring_vec_t ring_succ(input ring_vec_t c, input int w);
    ring_vec_t r;
    r = '0;
    for (int i = 0; i < RING_MAXW - 1; i++) begin
      if (i < w - 1) r[i] = c[i+1];
    end
    r[w-1] = c[0];
    return r;
  endfunction

  function automatic ring_class_t onehot_class(input ring_vec_t c);
    int n;
    n = $countones(c);
    if (n == 0) return CLS_ZERO;
    if (n == 1) return CLS_ONEHOT;
    return CLS_ILLEGAL;
  endfunction

  function automatic int onehot2idx(input ring_vec_t c, input int w);
    int idx;
    idx = 0;
    for (int i = 0; i < RING_MAXW; i++) begin
      if (i < w && c[i]) idx = w - 1 - i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_onehot_check.sv
// rtl/ring_onehot_check.sv - combinational classifier and one-hot to index converter
module ring_onehot_check
  import ring_pkg::*;
#(
  parameter int BIT = 4
) (
  input  logic [BIT-1:0]         i_ring,
  output ring_class_t            o_class,
  output logic [$clog2(BIT)-1:0] o_index
);

  localparam int IW = $clog2(BIT);

  ring_vec_t w_ext;

  assign w_ext   = ring_vec_t'(i_ring);
  assign o_class = onehot_class(w_ext);
  assign o_index = IW'(onehot2idx(w_ext, BIT));

endmodule

// File: rtl/ring_decoder.sv
// rtl/ring_decoder.sv - ring-counter receive monitor: lock tracking, index, lap and error counts
module ring_decoder
  import ring_pkg::*;
#(
  parameter int BIT    = 4,
  parameter int LOCK_N = 2,
  parameter int LAPW   = 8,
  parameter int ERRW   = 8
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   en,
  input  logic [BIT-1:0]         ring_in,
  output logic [$clog2(BIT)-1:0] index,
  output logic                   valid,
  output logic                   locked,
  output logic                   err,
  output logic [LAPW-1:0]        lap_count,
  output logic [ERRW-1:0]        err_count
);

  localparam int IW = $clog2(BIT);
  localparam int SW = $clog2(LOCK_N + 1);

  ring_state_t       r_state;
  logic [BIT-1:0]    r_prev;
  logic              r_prev_vld;
  logic [SW-1:0]     r_stepcnt;
  logic [IW-1:0]     r_index;
  logic              r_valid;
  logic              r_locked;
  logic              r_err;
  logic [LAPW-1:0]   r_lap;
  logic [ERRW-1:0]   r_errc;

  ring_class_t       w_class;
  logic [IW-1:0]     w_idx;
  logic [BIT-1:0]    w_succ;
  logic              w_is_succ;
  logic [SW-1:0]     w_step_nxt;
  logic [ERRW-1:0]   w_errc_nxt;

  ring_onehot_check #(.BIT(BIT)) u_check (
    .i_ring  (ring_in),
    .o_class (w_class),
    .o_index (w_idx)
  );

  assign w_succ     = BIT'(ring_succ(ring_vec_t'(r_prev), BIT));
  assign w_is_succ  = r_prev_vld && (ring_in == w_succ);
  assign w_step_nxt = r_stepcnt + SW'(1);
  assign w_errc_nxt = (&r_errc) ? r_errc : r_errc + ERRW'(1);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state    <= HUNT;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_stepcnt  <= '0;
      r_index    <= '0;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
      r_err      <= 1'b0;
      r_lap      <= '0;
      r_errc     <= '0;
    end else begin
      r_err <= 1'b0;
      if (en) begin
        case (r_state)
          HUNT: begin
            case (w_class)
              CLS_ONEHOT: begin
                r_prev     <= ring_in;
                r_prev_vld <= 1'b1;
                if (w_is_succ) begin
                  if (w_step_nxt >= SW'(LOCK_N)) begin
                    r_state   <= LOCKED;
                    r_stepcnt <= '0;
                    r_index   <= w_idx;
                    r_valid   <= 1'b1;
                    r_locked  <= 1'b1;
                  end else begin
                    r_stepcnt <= w_step_nxt;
                  end
                end else begin
                  r_stepcnt <= '0;
                end
              end
              CLS_ILLEGAL: begin
                r_err      <= 1'b1;
                r_errc     <= w_errc_nxt;
                r_stepcnt  <= '0;
                r_prev_vld <= 1'b0;
              end
              default: begin
                r_stepcnt  <= '0;
                r_prev_vld <= 1'b0;
              end
            endcase
          end
          LOCKED: begin
            case (w_class)
              CLS_ONEHOT: begin
                r_prev <= ring_in;
                if (w_is_succ) begin
                  r_index <= w_idx;
                  // Leaving the LSB-hot position closes a lap.
                  if (r_prev[0]) r_lap <= r_lap + LAPW'(1);
                end else begin
                  r_err      <= 1'b1;
                  r_errc     <= w_errc_nxt;
                  r_state    <= HUNT;
                  r_stepcnt  <= '0;
                  r_prev_vld <= 1'b1;
                  r_valid    <= 1'b0;
                  r_locked   <= 1'b0;
                end
              end
              CLS_ILLEGAL: begin
                r_err      <= 1'b1;
                r_errc     <= w_errc_nxt;
                r_state    <= HUNT;
                r_stepcnt  <= '0;
                r_prev_vld <= 1'b0;
                r_valid    <= 1'b0;
                r_locked   <= 1'b0;
              end
              default: begin
                r_state    <= HUNT;
                r_stepcnt  <= '0;
                r_prev_vld <= 1'b0;
                r_valid    <= 1'b0;
                r_locked   <= 1'b0;
              end
            endcase
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign index     = r_index;
  assign valid     = r_valid;
  assign locked    = r_locked;
  assign err       = r_err;
  assign lap_count = r_lap;
  assign err_count = r_errc;

endmodule

// File: tb/tb_ring_decoder.sv
// tb/tb_ring_decoder.sv - self-checking bench for ring_decoder
module tb_ring_decoder;

  typedef struct {
    logic       en;
    logic [3:0] ring;
    logic [1:0] idx;
    logic       vld;
    logic       lck;
    logic       err;
    logic [7:0] lap;
    logic [7:0] ec;
  } vec_t;

  logic       clk;
  logic       clr_n;
  logic       en;
  logic [3:0] ring_in;
  logic [1:0] index;
  logic       valid;
  logic       locked;
  logic       err;
  logic [7:0] lap_count;
  logic [7:0] err_count;

  int checks;
  int failures;
  int row;

  vec_t tbl[$];
  vec_t sb[$];

  ring_decoder #(.BIT(4), .LOCK_N(2), .LAPW(8), .ERRW(8)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .en        (en),
    .ring_in   (ring_in),
    .index     (index),
    .valid     (valid),
    .locked    (locked),
    .err       (err),
    .lap_count (lap_count),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input logic e, input logic [3:0] r, input int i,
                              input logic l, input logic er, input int lp, input int ec);
    vec_t v;
    v.en = e; v.ring = r; v.idx = 2'(i); v.vld = l; v.lck = l;
    v.err = er; v.lap = 8'(lp); v.ec = 8'(ec);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_out(input vec_t v);
    string t;
    t = $sformatf("row%0d", row);
    chk({t, "_index"},  int'(index),     int'(v.idx));
    chk({t, "_valid"},  int'(valid),     int'(v.vld));
    chk({t, "_locked"}, int'(locked),    int'(v.lck));
    chk({t, "_err"},    int'(err),       int'(v.err));
    chk({t, "_lap"},    int'(lap_count), int'(v.lap));
    chk({t, "_errcnt"}, int'(err_count), int'(v.ec));
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    en      = v.en;
    ring_in = v.ring;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp_out(e);
    row++;
  endtask

  initial begin
    checks = 0; failures = 0; row = 0;
    clr_n = 1'b0; en = 1'b0; ring_in = 4'b0000;

    // lock, two laps
    tbl.push_back(mk(1, 4'b1000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0100, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0010, 2, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 3, 1, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1000, 0, 1, 0, 1, 0));
    tbl.push_back(mk(1, 4'b0100, 1, 1, 0, 1, 0));
    tbl.push_back(mk(1, 4'b0010, 2, 1, 0, 1, 0));
    tbl.push_back(mk(1, 4'b0001, 3, 1, 0, 1, 0));
    tbl.push_back(mk(1, 4'b1000, 0, 1, 0, 2, 0));
    tbl.push_back(mk(1, 4'b0100, 1, 1, 0, 2, 0));
    tbl.push_back(mk(1, 4'b0010, 2, 1, 0, 2, 0));
    // run to 0100, then illegal, then relock
    tbl.push_back(mk(1, 4'b0001, 3, 1, 0, 2, 0));
    tbl.push_back(mk(1, 4'b1000, 0, 1, 0, 3, 0));
    tbl.push_back(mk(1, 4'b0100, 1, 1, 0, 3, 0));
    tbl.push_back(mk(1, 4'b0110, 1, 0, 1, 3, 1));
    tbl.push_back(mk(1, 4'b1000, 1, 0, 0, 3, 1));
    tbl.push_back(mk(1, 4'b0100, 1, 0, 0, 3, 1));
    tbl.push_back(mk(1, 4'b0010, 2, 1, 0, 3, 1));
    // locked at 1000, skip to 0010, relock through the wrap
    tbl.push_back(mk(1, 4'b0001, 3, 1, 0, 3, 1));
    tbl.push_back(mk(1, 4'b1000, 0, 1, 0, 4, 1));
    tbl.push_back(mk(1, 4'b0010, 0, 0, 1, 4, 2));
    tbl.push_back(mk(1, 4'b0001, 0, 0, 0, 4, 2));
    tbl.push_back(mk(1, 4'b1000, 0, 1, 0, 4, 2));
    // zero drops lock without error, then en=0 freezes everything
    tbl.push_back(mk(1, 4'b0100, 1, 1, 0, 4, 2));
    tbl.push_back(mk(1, 4'b0000, 1, 0, 0, 4, 2));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 4'b0110, 1, 0, 0, 4, 2));
    tbl.push_back(mk(1, 4'b0010, 1, 0, 0, 4, 2));
    tbl.push_back(mk(1, 4'b0001, 1, 0, 0, 4, 2));
    tbl.push_back(mk(1, 4'b1000, 0, 1, 0, 4, 2));
    tbl.push_back(mk(0, 4'b0001, 0, 1, 0, 4, 2));
    // stall, repeated stall in hunt, back-to-back illegal codes
    tbl.push_back(mk(1, 4'b1000, 0, 0, 1, 4, 3));
    tbl.push_back(mk(1, 4'b1000, 0, 0, 0, 4, 3));
    tbl.push_back(mk(1, 4'b1111, 0, 0, 1, 4, 4));
    tbl.push_back(mk(1, 4'b1100, 0, 0, 1, 4, 5));

    #12;
    chk("reset_index",  int'(index),     0);
    chk("reset_valid",  int'(valid),     0);
    chk("reset_locked", int'(locked),    0);
    chk("reset_err",    int'(err),       0);
    chk("reset_lap",    int'(lap_count), 0);
    chk("reset_errcnt", int'(err_count), 0);
    @(negedge clk);
    clr_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // error counter saturates while err keeps pulsing
    for (int i = 0; i < 252; i++) begin
      int ec;
      ec = (6 + i > 255) ? 255 : 6 + i;
      apply(mk(1, 4'b1111, 0, 0, 1, 4, ec));
    end

    // fresh run to lap_count=3, then asynchronous clear mid-cycle
    @(negedge clk);
    clr_n = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      logic [3:0] code;
      code = 4'b1000 >> (k % 4);
      apply(mk(1, code, (k >= 2) ? k % 4 : 0, k >= 2, 0, k / 4, 0));
    end
    en = 1'b0;
    #3;
    clr_n = 1'b0;
    #1;
    chk("async_index",  int'(index),     0);
    chk("async_valid",  int'(valid),     0);
    chk("async_locked", int'(locked),    0);
    chk("async_err",    int'(err),       0);
    chk("async_lap",    int'(lap_count), 0);
    chk("async_errcnt", int'(err_count), 0);
    @(negedge clk);
    clr_n = 1'b1;
    apply(mk(1, 4'b1000, 0, 0, 0, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_decoder.md
# ring_decoder

Receive-side monitor for the one-hot ring-counter bus. Samples a `BIT`-wide ring code on enabled cycles and checks that the code advances by exactly one position per sample (1000→0100→0010→0001→1000 for `BIT=4`). Converts the one-hot code to a binary index, counts completed laps, and flags illegal codes or skipped and stalled steps. It sits at the consumer end of a ring-counter link, such as a phase selector or a scan sequencer.

## Interface
Parameters:
- `BIT`, default 4: ring width; must be ≥ 2.
- `LOCK_N`, default 2: number of consecutive legal steps required to lock.
- `LAPW`, default 8: width of the lap counter.
- `ERRW`, default 8: width of the error counter.

Ports:
- `clk` input 1: single clock. All logic is on `posedge clk`.
- `clr_n` input 1: asynchronous, active-low reset.
- `en` input 1: sample strobe. `ring_in` is evaluated only in cycles where `en`=1.
- `ring_in` input `BIT`: ring code from the transmitting counter.
- `index` output `$clog2(BIT)`: position of the last legal code. MSB-hot = 0, LSB-hot = `BIT-1`.
- `valid` output 1: `index` is meaningful. Asserted only while in LOCKED.
- `locked` output 1: state == LOCKED.
- `err` output 1: one-cycle pulse when an error is detected.
- `lap_count` output `LAPW`: number of completed laps (wrapping step LSB-hot → MSB-hot).
- `err_count` output `ERRW`: total number of errors.

## Operation
- Code classes for each sample:
  - ZERO: all bits 0.
  - ONEHOT: exactly one bit set.
  - ILLEGAL: two or more bits set.
- Successor of a code is its rotate-right by one: `succ(c) = {c[0], c[BIT-1:1]}`.
- The block keeps a previous-code register `prev` and a step counter `stepcnt` (0..`LOCK_N`).
- States:
  - HUNT:
    - ONEHOT sample: `prev`←`ring_in`. If `ring_in == succ(prev)` and `prev` was valid, `stepcnt`++; otherwise `stepcnt`←0.
    - When `stepcnt` reaches `LOCK_N`, go to LOCKED.
    - ILLEGAL sample: `err` pulses, `err_count`++, `stepcnt`←0, `prev` is invalidated.
    - ZERO sample: `prev` is invalidated, `stepcnt`←0. No error.
  - LOCKED:
    - ONEHOT sample equal to `succ(prev)`: `prev`←`ring_in` and `index` is updated. If the step is LSB-hot→MSB-hot, `lap_count`++ (wraps modulo 2^`LAPW`).
    - ONEHOT sample not equal to `succ(prev)` (skip, stall, or reverse): `err` pulses, `err_count`++, go to HUNT with `prev`←`ring_in` and `stepcnt`←0.
    - ILLEGAL sample: `err` pulses, `err_count`++, go to HUNT with `prev` invalid.
    - ZERO sample (transmitter cleared or disabled): go to HUNT, no error, `prev` invalid. `lap_count` is kept.
- `en`=0: no state change, no counting, all outputs hold.
- `err_count` saturates at all-ones. The `err` pulse still fires when `err_count` is saturated.
- `lap_count` is counted only in LOCKED. The wrap step that completes the lock is not counted as a lap.

## Timing
- Reset values: state=HUNT, `prev` invalid, `stepcnt`=0, `index`=0, `valid`=0, `locked`=0, `err`=0, `lap_count`=0, `err_count`=0.
- All outputs are registered. A sample taken at edge N is reflected at the outputs after edge N, i.e. one cycle of latency.
- `err` is high for exactly one cycle per offending sample. Back-to-back bad samples produce back-to-back pulses.
- With `LOCK_N`=2, the earliest lock is the third consecutive legal sample: `locked` rises after the edge that samples the second legal successor.
- `valid` and `locked` drop in the cycle after a sample that causes an exit from LOCKED.
- Asserting `clr_n`=0 at any time, including mid-lap, immediately forces the reset values without waiting for a clock edge. Deassertion is synchronized externally.

## Structure
- Package `ring_pkg`:
  - state enum `{HUNT, LOCKED}`.
  - function `ring_succ`.
  - function `onehot_class` returning ZERO, ONEHOT or ILLEGAL.
  - function `onehot2idx`.
- Sub-module `ring_onehot_check`: purely combinational. Takes `ring_in` and produces the class and the binary index. Instantiated once.
- Top level contains the state register, `prev`, `stepcnt`, the counters and the output registers.

## Test plan
- Reset, then `en`=1 with 1000,0100,0010 → `locked`=1 after the third sample, `index`=2, `err`=0.
- Locked and running for 2 full laps (8 further legal samples ending at 0010) → `lap_count`=2, `err_count`=0.
- Locked at 0100, then inject 0110 → single `err` pulse, `err_count`=1, `locked`=0. Next 1000,0100,0010 → relock.
- Locked at 1000, then inject 0010 (skip) → `err` pulse, state HUNT, `prev`=0010. Then 0001,1000 → relock with `index`=0, `lap_count` unchanged.
- Locked, then inject 0000 → `locked`=0, `err`=0, `err_count` unchanged, `lap_count` held. `en`=0 for 5 cycles → outputs frozen.
- Locked with `lap_count`=3, assert `clr_n` low mid-cycle → all outputs return to reset values before the next clock edge.
